// File: rtl/seq_det_pkg.sv
// Shared types for the sequence-detector scheduler.
// Scheduler FSM state encoding and default sizing.
package seq_det_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Ports: req_i requests, ptr_i first index to search,
//        gnt_o one-hot winner, idx_o winner index, any_o some request set.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Shares one serial sequence detector among N_REQ requesters:
// round-robin grant, clear, shift word MSB-first, count det_out hits.
// Ports: clk/rstn; req/req_data/gnt requester side;
//        det_clr/det_x/det_out detector side; rsp_* response handshake.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    det_clr,
    output logic                    det_x,
    input  logic                    det_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [CNT_W-1:0]        rsp_count
);

    localparam int BIT_W = $clog2(DATA_W);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        word_d  = word_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    word_d  = req_data[int'(arb_idx)*DATA_W +: DATA_W];
                    id_d    = arb_idx;
                    ptr_d   = (arb_idx == ID_W'(N_REQ - 1)) ? '0
                              : arb_idx + ID_W'(1);
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // word_q MSB always drives det_x; shift it away each bit
                word_d = {word_q[DATA_W-2:0], 1'b0};
                bit_d  = bit_q + BIT_W'(1);
                // det_out lags det_x by one cycle, so bit 0 has no sample yet
                if (bit_q != '0) begin
                    cnt_d = cnt_q + CNT_W'(det_out);
                end
                if (bit_q == BIT_W'(DATA_W - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d   = cnt_q + CNT_W'(det_out);
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            word_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            word_q  <= word_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Detector is held cleared for the whole reset, not just CLEAR
    assign det_clr   = ~rstn | (state_q == CLEAR);
    assign det_x     = (state_q == SHIFT) & word_q[DATA_W-1];
    assign gnt       = gnt_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_count = cnt_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: transaction-level model plus
// directed and random requester traffic, stub or 101 detector.
module tb_seq_det_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic           clk       = 1'b0;
    logic           rstn      = 1'b1;
    logic [N-1:0]   req       = '0;
    logic [N*W-1:0] req_data  = '0;
    logic           rsp_ready = 1'b0;
    logic [N-1:0]   gnt;
    logic           det_clr;
    logic           det_x;
    logic           det_out;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [CW-1:0]  rsp_count;

    bit use_real = 1'b0;
    bit persist  = 1'b0;

    seq_det_scheduler #(
        .N_REQ(N), .DATA_W(W), .ID_W(IDW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data),
        .gnt(gnt), .det_clr(det_clr), .det_x(det_x),
        .det_out(det_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_count(rsp_count)
    );

    always #5 clk = ~clk;

    // Detector environment: stub delay or a Moore "101" detector
    logic       stub_q;
    logic [2:0] fsm_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stub_q <= 1'b0;
            fsm_q  <= 3'd0;
        end else if (det_clr) begin
            stub_q <= 1'b0;
            fsm_q  <= 3'd0;
        end else begin
            stub_q <= det_x;
            case (fsm_q)
                3'd0:    fsm_q <= det_x ? 3'd1 : 3'd0;
                3'd1:    fsm_q <= det_x ? 3'd1 : 3'd2;
                3'd2:    fsm_q <= det_x ? 3'd3 : 3'd0;
                default: fsm_q <= det_x ? 3'd1 : 3'd2;
            endcase
        end
    end
    assign det_out = use_real ? (fsm_q == 3'd3) : stub_q;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    bit             m_active, m_idle, m_prev_valid, m_real;
    int             m_g, m_id, m_ptr;
    logic [W-1:0]   m_word;

    int  gnt_log[$], gnt_cyc[$], rsp_id_log[$], rsp_cnt_log[$];
    int  hs_cyc     = -100;
    bit  last_valid = 1'b0;

    function automatic int exp_count(logic [W-1:0] w, bit rl);
        int n;
        if (!rl) return $countones(w);
        n = 0;
        for (int k = 2; k < W; k++)
            if (w[W+1-k] && !w[W-k] && w[W-1-k]) n++;
        return n;
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d",
                      nm, cyc, act, exp);
    endtask

    task automatic set_word(input int i, input logic [W-1:0] w);
        req_data[i*W +: W] = w;
    endtask

    task automatic step();
        int idx, off;
        bit was_idle, e_clr, e_x, e_valid;
        logic [N-1:0] e_gnt;
        @(posedge clk);
        #1;
        if (rstn && last_valid && rsp_ready) hs_cyc = cyc;
        cyc++;
        e_gnt = '0;
        if (!rstn) begin
            m_active = 0; m_ptr = 0; m_idle = 1; m_prev_valid = 0;
            check("rst_gnt", 32'(gnt), 0);
            check("rst_clr", 32'(det_clr), 1);
            check("rst_x", 32'(det_x), 0);
            check("rst_valid", 32'(rsp_valid), 0);
            check("rst_id", 32'(rsp_id), 0);
            check("rst_count", 32'(rsp_count), 0);
        end else begin
            was_idle = m_idle;
            if (m_prev_valid && rsp_ready) begin
                m_active = 0;
            end else if (was_idle && req != '0) begin
                idx = -1;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (idx < 0 && req[j]) idx = j;
                end
                m_ptr    = (idx + 1) % N;
                m_active = 1;
                m_g      = cyc;
                m_id     = idx;
                m_word   = req_data[idx*W +: W];
                m_real   = use_real;
                e_gnt[idx] = 1'b1;
            end
            m_idle  = !m_active;
            off     = cyc - m_g - 1;
            e_clr   = m_active && (cyc == m_g);
            e_x     = 1'b0;
            if (m_active && off >= 0 && off < W) e_x = m_word[W-1-off];
            e_valid = m_active && (cyc >= m_g + W + 2);
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("det_clr", 32'(det_clr), 32'(e_clr));
            check("det_x", 32'(det_x), 32'(e_x));
            check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
            if (e_valid) begin
                check("rsp_id", 32'(rsp_id), m_id);
                check("rsp_count", 32'(rsp_count), exp_count(m_word, m_real));
            end
            m_prev_valid = e_valid;
        end
        if (gnt != '0) begin
            gnt_log.push_back(oh_idx(gnt));
            gnt_cyc.push_back(cyc);
        end
        if (rsp_valid && !last_valid) begin
            rsp_id_log.push_back(int'(rsp_id));
            rsp_cnt_log.push_back(int'(rsp_count));
        end
        last_valid = rsp_valid;
        for (int i = 0; i < N; i++)
            if (gnt[i] && !persist) req[i] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_rsp(input int n, input int limit);
        for (int i = 0; i < limit && rsp_cnt_log.size() < n; i++) step();
        check("rsp_wait", 32'(rsp_cnt_log.size() >= n), 1);
    endtask

    task automatic run_gnt(input int n, input int limit);
        for (int i = 0; i < limit && gnt_log.size() < n; i++) step();
        check("gnt_wait", 32'(gnt_log.size() >= n), 1);
    endtask

    task automatic clear_logs();
        gnt_log.delete(); gnt_cyc.delete();
        rsp_id_log.delete(); rsp_cnt_log.delete();
        hs_cyc = -100;
    endtask

    task automatic reset_dut();
        rstn = 1'b0; req = '0; rsp_ready = 1'b0; persist = 1'b0;
        step(); step();
        clear_logs();
        last_valid = 1'b0;
        rstn = 1'b1;
    endtask

    int e2g[5] = '{0, 1, 2, 3, 0};
    int e2c[4] = '{8, 0, 4, 2};
    int e3g[3] = '{2, 0, 2};

    initial begin
        #2;
        check("pin_pop", exp_count(8'hB5, 1'b0), 5);
        check("pin_101", exp_count(8'b1011_0110, 1'b1), 2);
        check("pin_101b", exp_count(8'b1010_1010, 1'b1), 3);

        // single job, latency and popcount
        reset_dut();
        set_word(0, 8'hB5); req = 4'b0001; rsp_ready = 1'b1;
        run_rsp(1, 40); run(3);
        check("t1_ngnt", gnt_log.size(), 1);
        if (gnt_log.size() > 0 && rsp_cnt_log.size() > 0) begin
            check("t1_gnt", gnt_log[0], 0);
            check("t1_id", rsp_id_log[0], 0);
            check("t1_count", rsp_cnt_log[0], 5);
        end

        // all requesting: rotation order and counts
        reset_dut();
        set_word(0, 8'hFF); set_word(1, 8'h00);
        set_word(2, 8'h0F); set_word(3, 8'h81);
        persist = 1'b1; req = 4'hF; rsp_ready = 1'b1;
        run_gnt(5, 80);
        persist = 1'b0; req = '0;
        run(16);
        for (int i = 0; i < 5; i++)
            if (i < gnt_log.size()) check("t2_order", gnt_log[i], e2g[i]);
        for (int i = 0; i < 4; i++)
            if (i < rsp_cnt_log.size()) check("t2_count", rsp_cnt_log[i], e2c[i]);

        // pointer wrap after grant to 2
        reset_dut();
        set_word(2, 8'($urandom)); req = 4'b0100; rsp_ready = 1'b1;
        run_rsp(1, 40);
        set_word(0, 8'($urandom)); set_word(2, 8'($urandom));
        req = 4'b0101;
        run_gnt(3, 60); run(16);
        for (int i = 0; i < 3; i++)
            if (i < gnt_log.size()) check("t3_order", gnt_log[i], e3g[i]);

        // back-pressure on the response
        reset_dut();
        set_word(0, 8'h3C); req = 4'b0001; rsp_ready = 1'b0;
        run_rsp(1, 40);
        set_word(1, 8'hE7); req[1] = 1'b1;
        run(5);
        check("t4_hold_valid", 32'(rsp_valid), 1);
        check("t4_hold_id", 32'(rsp_id), 0);
        check("t4_hold_count", 32'(rsp_count), 4);
        check("t4_nogrant", gnt_log.size(), 1);
        rsp_ready = 1'b1;
        run_gnt(2, 10);
        if (gnt_cyc.size() > 1) check("t4_regrant", gnt_cyc[1] - hs_cyc, 2);
        run_rsp(2, 20); run(2);
        if (rsp_cnt_log.size() > 1) check("t4_count2", rsp_cnt_log[1], 6);

        // reset in the middle of SHIFT bit 3
        reset_dut();
        set_word(2, 8'hA5); req = 4'b0100; rsp_ready = 1'b1;
        run_gnt(1, 10); run(4);
        #1 rstn = 1'b0;
        #1;
        check("t5_gnt", 32'(gnt), 0);
        check("t5_clr", 32'(det_clr), 1);
        check("t5_x", 32'(det_x), 0);
        check("t5_valid", 32'(rsp_valid), 0);
        check("t5_id", 32'(rsp_id), 0);
        check("t5_count", 32'(rsp_count), 0);
        step(); step();
        clear_logs(); last_valid = 1'b0;
        rstn = 1'b1;
        set_word(1, 8'h5A); req = 4'b0010;
        run_rsp(1, 40); run(2);
        check("t5_ngnt", gnt_log.size(), 1);
        check("t5_nrsp", rsp_cnt_log.size(), 1);
        if (gnt_log.size() > 0 && rsp_cnt_log.size() > 0) begin
            check("t5_gnt_idx", gnt_log[0], 1);
            check("t5_rsp_id", rsp_id_log[0], 1);
            check("t5_rsp_count", rsp_cnt_log[0], 4);
        end

        // real detector
        reset_dut();
        use_real = 1'b1;
        set_word(0, 8'b1011_0110); req = 4'b0001; rsp_ready = 1'b1;
        run_rsp(1, 40); run(2);
        if (rsp_cnt_log.size() > 0) check("t6_count", rsp_cnt_log[0], 2);

        // random traffic with both detectors
        for (int r = 0; r < 2; r++) begin
            reset_dut();
            use_real = (r == 1);
            for (int c = 0; c < 1200; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && $urandom_range(0, 3) == 0) begin
                        set_word(i, 8'($urandom));
                        req[i] = 1'b1;
                    end else if (req[i] && $urandom_range(0, 19) == 0) begin
                        req[i] = 1'b0;
                    end
                end
                rsp_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            req = '0; rsp_ready = 1'b1;
            run(30);
            check("rnd_jobs", 32'(rsp_cnt_log.size() > 20), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
